clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

Parametrised multi-channel clock divider that generates CHANNELS independent square-wave slow clocks, plus single-cycle rising-edge ticks, from the board clock. Each channel's half-period is reprogrammable at run time through a valid/ready port, and updates are applied glitch-free at a period boundary. Channels can be frozen individually and phase-aligned together. It replaces the fixed single-rate dividers that feed display refresh, debounce and animation logic.

## Interface
- CHANNELS, 4, number of independent divider channels (≥1)
- WIDTH, 25, width of each half-period counter and divisor
- DEFAULT_HALF, 24999999, half-period loaded into every channel at reset (2 Hz from 100 MHz)
- CHW, derived, max(1, clog2(CHANNELS)), width of cfg_ch
- CLOCK  in  1  system clock; all state changes on its rising edge
- RESET  in  1  asynchronous, active-high reset
- en  in  CHANNELS  per-channel run enable
- sync  in  1  synchronous restart of all channels in phase
- cfg_valid  in  1  divisor write request
- cfg_ch  in  CHW  target channel
- cfg_half  in  WIDTH  new half-period value H
- cfg_ready  out  1  write can be accepted this cycle
- clk_out  out  CHANNELS  divided clocks (registered)
- tick  out  CHANNELS  one-cycle pulse per rising clk_out edge (registered)

## Operation
- Per-channel state: cnt[WIDTH], half[WIDTH], pend_val[WIDTH], pend flag, clk_out, tick.
- Reset (async, any time, including mid-transfer): cnt=0, half=DEFAULT_HALF, pend=0, clk_out=0, tick=0 on all channels; in-flight config is discarded.
- Output frequency = f_CLOCK / (2·(H+1)); H=0 gives CLOCK/2. Duty cycle is exactly 50%.
- Counting (en=1, sync=0): if cnt==half, then cnt←0 and clk_out toggles; otherwise cnt←cnt+1. Arithmetic is unsigned, with no wrap beyond half.
- tick←1 only on the edge where clk_out goes 0→1; otherwise tick←0.
- en=0: cnt and clk_out hold, tick←0. A pending value is applied on the next edge with cnt←0.
- Config handshake: a write is accepted on an edge where cfg_valid&&cfg_ready. The value goes to pend_val and pend←1.
- cfg_ready = ~pend[cfg_ch], combinational on cfg_ch. If cfg_ch ≥ CHANNELS, cfg_ready=1 and the write is accepted and dropped.
- Pending apply: on the edge where clk_out toggles 1→0, half←pend_val, cnt←0, pend←0. The new rate therefore starts on a full low phase, and no runt pulses occur.
- sync=1 (priority over en and counting): all channels take cnt←0, clk_out←0, tick←0, and any pend is applied. A write accepted on the same edge goes directly into half with pend=0.
- Write accepted on the same edge as a pending apply for that channel: impossible, because cfg_ready=0 while pend=1.

## Timing
- All outputs are registered; cfg_ready is the only combinational output.
- From reset release or sync with half=H, en=1: clk_out rises after edge H+1 and falls after edge 2(H+1). tick is high for exactly the cycle following edge H+1, then again every 2(H+1) edges.
- Config latency: at most one remaining high phase plus the current count, i.e. ≤ 2(H_old+1) edges, before the new H takes effect. cfg_ready deasserts the cycle after acceptance and reasserts the cycle after the apply.
- With en=0, the apply happens 1 edge after acceptance.

## Test plan
- DEFAULT_HALF=3, CHANNELS=2, en=11 after reset: clk_out high after edges 4–7, low after edges 8–11. tick is high only after edges 4 and 12, with both channels identical.
- Write ch0 H=1 during the high phase at edge 5: cfg_ready=0 from edge 5 to 8. clk_out[0] falls after edge 8, then rises after edge 10 with period 4; ch1 is unchanged.
- Second write to ch0 while pend=1: cfg_ready=0 and no acceptance. cfg_ch=3 with CHANNELS=2: cfg_ready=1 and no channel changes.
- en[1]=0 for 5 cycles mid-high-phase: clk_out[1] stays high and cnt is frozen. No tick is produced, and counting resumes exactly where it stopped.
- sync pulse with channels at different phases and a pending write on ch1: all clk_out=0 next cycle, ch1 uses the new H, and both channels' first rising edges follow the timing above.
- Assert RESET asynchronously mid-high-phase with pend=1: clk_out/tick go 0 immediately, half=DEFAULT_HALF, and cfg_ready=1.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider: per-channel 50% duty slow clocks and rising-edge ticks,
// with divisor updates held pending until the end of a high phase so no runt pulses appear.
module clock_divider_bank #(
  parameter int          CHANNELS     = 4,
  parameter int          WIDTH        = 25,
  parameter int unsigned DEFAULT_HALF = 24999999,
  localparam int         CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                cfg_valid,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_half,
  output logic                cfg_ready,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] half_q, half_d;
  logic [CHANNELS-1:0][WIDTH-1:0] pendVal_q, pendVal_d;
  logic [CHANNELS-1:0]            pend_q, pend_d;
  logic [CHANNELS-1:0]            clk_q, clk_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;
  logic [CHANNELS-1:0]            wrSel;

  // Out-of-range channel numbers match no channel, so they stay ready and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    wrSel     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CHW'(i)) cfg_ready = ~pend_q[i];
    end
    for (int i = 0; i < CHANNELS; i++) begin
      wrSel[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    half_d    = half_q;
    pendVal_d = pendVal_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    tick_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_q[i]) begin
          half_d[i] = pendVal_q[i];
          pend_d[i] = 1'b0;
        end
        // A write landing on a sync edge bypasses the pending slot entirely.
        if (wrSel[i]) half_d[i] = cfg_half;
      end else begin
        if (en[i]) begin
          if (cnt_q[i] == half_q[i]) begin
            cnt_d[i] = '0;
            clk_d[i] = ~clk_q[i];
            if (!clk_q[i]) begin
              tick_d[i] = 1'b1;
            end else if (pend_q[i]) begin
              half_d[i] = pendVal_q[i];
              pend_d[i] = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
          end
        end else if (pend_q[i]) begin
          half_d[i] = pendVal_q[i];
          cnt_d[i]  = '0;
          pend_d[i] = 1'b0;
        end
        // wrSel implies pend_q was clear, so this never collides with an apply above.
        if (wrSel[i]) begin
          pendVal_d[i] = cfg_half;
          pend_d[i]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      half_q    <= {CHANNELS{WIDTH'(DEFAULT_HALF)}};
      pendVal_q <= '0;
      pend_q    <= '0;
      clk_q     <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      pendVal_q <= pendVal_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: directed per-edge vectors queue their expected outputs,
// and a monitor pops one entry after every rising edge and compares.
module tb_clock_divider_bank;

  localparam int CH = 3;
  localparam int W  = 8;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_half = '0;
  logic          cfg_ready;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;

  typedef struct {
    int            edgeNum;
    logic [CH-1:0] clk;
    logic [CH-1:0] tick;
    logic          ready;
  } expItem_t;

  expItem_t expQ[$];
  expItem_t cur;
  int       total = 0;
  int       bad = 0;
  int       edgeNum = 0;

  clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_HALF(3)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .en(en), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_ready(cfg_ready),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string name, input int idx, input logic [7:0] actual,
                             input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s edge %0d: got %b expected %b", name, idx, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at a falling edge and queues the outputs expected after the next rising edge.
  task automatic applyStimulus(input logic [CH-1:0] e, input logic s, input logic v,
                               input logic [1:0] c, input logic [W-1:0] h,
                               input logic [CH-1:0] eClk, input logic [CH-1:0] eTick, input logic eRdy);
    expItem_t item;
    en = e; sync = s; cfg_valid = v; cfg_ch = c; cfg_half = h;
    edgeNum++;
    item.edgeNum = edgeNum;
    item.clk     = eClk;
    item.tick    = eTick;
    item.ready   = eRdy;
    expQ.push_back(item);
    @(negedge CLOCK);
  endtask

  always @(posedge CLOCK) begin
    #1;
    if (expQ.size() != 0) begin
      cur = expQ.pop_front();
      checkOutput("clk_out", cur.edgeNum, 8'(clk_out), 8'(cur.clk));
      checkOutput("tick", cur.edgeNum, 8'(tick), 8'(cur.tick));
      checkOutput("cfg_ready", cur.edgeNum, 8'(cfg_ready), 8'(cur.ready));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge CLOCK);
    checkOutput("reset_clk", 0, 8'(clk_out), 8'h00);
    checkOutput("reset_tick", 0, 8'(tick), 8'h00);
    checkOutput("reset_ready", 0, 8'(cfg_ready), 8'h01);
    RESET = 1'b0;

    // Both active channels at the default half-period, ch0 reprogrammed to H=1 mid high phase.
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b011, 1);
    applyStimulus(3'b011, 0, 1, 2'd0, 8'd1, 3'b011, 3'b000, 0);
    applyStimulus(3'b011, 0, 1, 2'd0, 8'd2, 3'b011, 3'b000, 0);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 0);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 1, 2'd3, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b001, 3'b001, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b001, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 1);
    // ch1 frozen for five edges while high.
    applyStimulus(3'b001, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 1);
    applyStimulus(3'b001, 0, 0, 2'd0, 8'd0, 3'b011, 3'b001, 1);
    applyStimulus(3'b001, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 1);
    applyStimulus(3'b001, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 1);
    applyStimulus(3'b001, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b001, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b010, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    // Pending write on ch1, then sync with a direct write to ch0.
    applyStimulus(3'b011, 0, 1, 2'd1, 8'd2, 3'b001, 3'b001, 0);
    applyStimulus(3'b011, 0, 0, 2'd1, 8'd0, 3'b001, 3'b000, 0);
    applyStimulus(3'b011, 1, 1, 2'd0, 8'd2, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b011, 1);
    applyStimulus(3'b011, 0, 1, 2'd0, 8'd5, 3'b011, 3'b000, 0);
    applyStimulus(3'b011, 0, 0, 2'd0, 8'd0, 3'b011, 3'b000, 0);

    // Asynchronous reset mid high phase with ch0 pending.
    RESET = 1'b1;
    #1;
    checkOutput("async_reset_clk", edgeNum, 8'(clk_out), 8'h00);
    checkOutput("async_reset_tick", edgeNum, 8'(tick), 8'h00);
    checkOutput("async_reset_ready", edgeNum, 8'(cfg_ready), 8'h01);
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    edgeNum = 100;

    // Defaults restored; ch2 programmed to H=0 while disabled, then enabled.
    applyStimulus(3'b011, 0, 1, 2'd2, 8'd0, 3'b000, 3'b000, 0);
    applyStimulus(3'b011, 0, 0, 2'd2, 8'd0, 3'b000, 3'b000, 1);
    applyStimulus(3'b111, 0, 0, 2'd2, 8'd0, 3'b100, 3'b100, 1);
    applyStimulus(3'b111, 0, 0, 2'd2, 8'd0, 3'b011, 3'b011, 1);
    applyStimulus(3'b111, 0, 0, 2'd2, 8'd0, 3'b111, 3'b100, 1);
    applyStimulus(3'b111, 0, 0, 2'd2, 8'd0, 3'b011, 3'b000, 1);
    applyStimulus(3'b111, 0, 0, 2'd2, 8'd0, 3'b111, 3'b100, 1);
    applyStimulus(3'b111, 0, 0, 2'd2, 8'd0, 3'b000, 3'b000, 1);

    for (int i = 0; i < 4 && expQ.size() != 0; i++) @(negedge CLOCK);
    if (expQ.size() != 0) begin
      bad++;
      total++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
